// File: rtl/pa_pkg.sv
// Shared types for the protocol adapter transmit path.
package pa_pkg;

   localparam int CRD_W_DEFAULT = 6;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      DATA = 2'd1,
      RESP = 2'd2,
      CRD  = 2'd3
   } flit_sel_e;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } sched_state_e;

endpackage

// File: rtl/rdi_tx_scheduler_if.sv
// Scheduler <-> write datapath / RDI transmit handshake bundle.
interface rdi_tx_if
   import pa_pkg::*;
#(
   parameter int CRD_W = CRD_W_DEFAULT
) ();
   logic             data_req_i;
   logic             data_pop_o;
   logic             resp_req_i;
   logic             resp_ack_o;
   flit_sel_e        sel_o;
   logic [CRD_W-1:0] crd_flit_cnt_o;
   logic             lp_irdy_o;
   logic             pl_trdy_i;

   modport master (
      input  data_req_i, resp_req_i, pl_trdy_i,
      output data_pop_o, resp_ack_o, sel_o, crd_flit_cnt_o, lp_irdy_o
   );

   modport slave (
      output data_req_i, resp_req_i, pl_trdy_i,
      input  data_pop_o, resp_ack_o, sel_o, crd_flit_cnt_o, lp_irdy_o
   );
endinterface

// File: rtl/tx_credit_counter.sv
// Saturating credit counter: netted increment/decrement in one cycle,
// clamps at MAX on overflow, holds on underflow, sticky error on either.
module tx_credit_counter #(
   parameter int W    = 6,
   parameter int INIT = 0,
   parameter int MAX  = (1 << W) - 1
) (
   input  logic         clk_i,
   input  logic         rst_n,
   input  logic [W-1:0] inc_i,
   input  logic [W-1:0] dec_i,
   output logic [W-1:0] cnt_o,
   output logic         err_o
);
   logic [W-1:0] cnt_q, cnt_d;
   logic         err_q, err_d;
   logic [W:0]   up;
   logic [W:0]   net;

   assign up  = {1'b0, cnt_q} + {1'b0, inc_i};
   assign net = up - {1'b0, dec_i};

   // Next count with saturation and error detection.
   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if (up < {1'b0, dec_i}) begin
         err_d = 1'b1;
      end else if (net > (W+1)'(MAX)) begin
         cnt_d = W'(MAX);
         err_d = 1'b1;
      end else begin
         cnt_d = net[W-1:0];
      end
   end

   // Counter and sticky error registers.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= W'(INIT);
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign cnt_o = cnt_q;
   assign err_o = err_q;
endmodule

// File: rtl/rdi_tx_scheduler.sv
// RDI transmit slot scheduler: arbitrates data, response and credit-return
// flits, tracks remote and pending local credits.
//
// state | meaning
// IDLE  | no flit offered; arbitrate and grant when enabled
// SEND  | flit offered on RDI (lp_irdy high); wait for pl_trdy
module rdi_tx_scheduler
   import pa_pkg::*;
#(
   parameter int CRD_W      = CRD_W_DEFAULT,
   parameter int CRD_INIT   = 16,
   parameter int CRD_THRESH = 4,
   parameter int CRD_TMO    = 64
) (
   input  logic             clk_i,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             rx_pop_i,
   input  logic             crd_ret_i,
   input  logic [CRD_W-1:0] crd_ret_cnt_i,
   output logic [CRD_W-1:0] tx_crd_o,
   output logic [CRD_W-1:0] rx_pend_o,
   output logic             crd_err_o,
   rdi_tx_if.master         tx
);
   localparam int TMR_W = $clog2(CRD_TMO + 1);

   sched_state_e     state_q, state_d;
   flit_sel_e        sel_q, sel_d, grant;
   logic [CRD_W-1:0] cnt_q, cnt_d;
   logic             rr_resp_q, rr_resp_d;
   logic [TMR_W-1:0] tmr_q;
   logic [CRD_W-1:0] tx_crd, rx_pend;
   logic             tx_err, rx_err;
   logic             accept, data_pop, crd_done;
   logic             data_ok, resp_ok, crd_urg, crd_tmo;

   assign accept   = (state_q == SEND) && tx.pl_trdy_i;
   assign data_pop = accept && (sel_q == DATA);
   assign crd_done = accept && (sel_q == CRD);

   assign data_ok = tx.data_req_i && (tx_crd != '0);
   assign resp_ok = tx.resp_req_i;
   assign crd_urg = rx_pend >= CRD_W'(CRD_THRESH);
   assign crd_tmo = (rx_pend != '0) && (tmr_q == TMR_W'(CRD_TMO));

   // Arbitration, next state and registered selections.
   always_comb begin
      grant     = NONE;
      state_d   = state_q;
      sel_d     = sel_q;
      cnt_d     = cnt_q;
      rr_resp_d = rr_resp_q;
      if (crd_urg)                 grant = CRD;
      else if (resp_ok && data_ok) grant = rr_resp_q ? RESP : DATA;
      else if (resp_ok)            grant = RESP;
      else if (data_ok)            grant = DATA;
      else if (crd_tmo)            grant = CRD;
      case (state_q)
         IDLE: begin
            if (enable && (grant != NONE)) begin
               state_d = SEND;
               sel_d   = grant;
               if (grant == CRD)  cnt_d     = rx_pend;
               if (grant == RESP) rr_resp_d = 1'b0;
               if (grant == DATA) rr_resp_d = 1'b1;
            end
         end
         SEND: begin
            if (tx.pl_trdy_i) begin
               state_d = IDLE;
               sel_d   = NONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM and selection registers.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         sel_q     <= NONE;
         cnt_q     <= '0;
         rr_resp_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         cnt_q     <= cnt_d;
         rr_resp_q <= rr_resp_d;
      end
   end

   // Idle timer for returning stale pending credits.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n)                           tmr_q <= '0;
      else if ((rx_pend == '0) || crd_done) tmr_q <= '0;
      else if (tmr_q != TMR_W'(CRD_TMO))    tmr_q <= tmr_q + 1'b1;
   end

   tx_credit_counter #(.W(CRD_W), .INIT(CRD_INIT), .MAX(CRD_INIT)) u_tx_crd (
      .clk_i (clk_i),
      .rst_n (rst_n),
      .inc_i (crd_ret_i ? crd_ret_cnt_i : '0),
      .dec_i ({{(CRD_W-1){1'b0}}, data_pop}),
      .cnt_o (tx_crd),
      .err_o (tx_err)
   );

   tx_credit_counter #(.W(CRD_W), .INIT(0), .MAX((1 << CRD_W) - 1)) u_rx_pend (
      .clk_i (clk_i),
      .rst_n (rst_n),
      .inc_i ({{(CRD_W-1){1'b0}}, rx_pop_i}),
      .dec_i (crd_done ? cnt_q : '0),
      .cnt_o (rx_pend),
      .err_o (rx_err)
   );

   assign tx.data_pop_o     = data_pop;
   assign tx.resp_ack_o     = accept && (sel_q == RESP);
   assign tx.sel_o          = sel_q;
   assign tx.crd_flit_cnt_o = cnt_q;
   assign tx.lp_irdy_o      = (state_q == SEND);
   assign tx_crd_o          = tx_crd;
   assign rx_pend_o         = rx_pend;
   assign crd_err_o         = tx_err | rx_err;
endmodule

// File: tb/tb_rdi_tx_scheduler.sv
// Directed bench for rdi_tx_scheduler: per-cycle vector table plus
// hand-written sequences for credit exhaustion, timeout, stall and reset.
module tb_rdi_tx_scheduler;
   import pa_pkg::*;

   localparam int W = 6;

   logic         clk_i = 1'b0;
   logic         rst_n = 1'b0;
   logic         enable = 1'b0;
   logic         rx_pop_i = 1'b0;
   logic         crd_ret_i = 1'b0;
   logic [W-1:0] crd_ret_cnt_i = '0;
   logic [W-1:0] tx_crd_o, rx_pend_o;
   logic         crd_err_o;

   int checks = 0;
   int errors = 0;

   rdi_tx_if #(.CRD_W(W)) tx_if ();

   rdi_tx_scheduler #(
      .CRD_W(W), .CRD_INIT(16), .CRD_THRESH(4), .CRD_TMO(64)
   ) dut (
      .clk_i         (clk_i),
      .rst_n         (rst_n),
      .enable        (enable),
      .rx_pop_i      (rx_pop_i),
      .crd_ret_i     (crd_ret_i),
      .crd_ret_cnt_i (crd_ret_cnt_i),
      .tx_crd_o      (tx_crd_o),
      .rx_pend_o     (rx_pend_o),
      .crd_err_o     (crd_err_o),
      .tx            (tx_if)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic      dreq, rreq, trdy, pop;
      logic      irdy;
      flit_sel_e sel;
      logic      dpop, rack;
      int        tx, pend, fcnt;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      enable = 1'b1;
      rx_pop_i = 1'b0;
      crd_ret_i = 1'b0;
      crd_ret_cnt_i = '0;
      tx_if.data_req_i = 1'b0;
      tx_if.resp_req_i = 1'b0;
      tx_if.pl_trdy_i = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
   endtask

   function automatic vec_t mk(logic dreq, logic rreq, logic pop, logic irdy, flit_sel_e sel,
                               logic dpop, logic rack, int tx, int pend, int fcnt);
      vec_t v;
      v.dreq = dreq; v.rreq = rreq; v.trdy = 1'b1; v.pop = pop;
      v.irdy = irdy; v.sel = sel; v.dpop = dpop; v.rack = rack;
      v.tx = tx; v.pend = pend; v.fcnt = fcnt;
      return v;
   endfunction

   initial begin
      int pops, last, saw, got;

      // Round-robin, credit-flit table (one entry per cycle).
      vecs[0]  = mk(1, 1, 0, 0, NONE, 0, 0, 16, 0, 0);
      vecs[1]  = mk(1, 1, 0, 1, RESP, 0, 1, 16, 0, 0);
      vecs[2]  = mk(1, 1, 0, 0, NONE, 0, 0, 16, 0, 0);
      vecs[3]  = mk(1, 1, 0, 1, DATA, 1, 0, 16, 0, 0);
      vecs[4]  = mk(1, 1, 0, 0, NONE, 0, 0, 15, 0, 0);
      vecs[5]  = mk(1, 1, 0, 1, RESP, 0, 1, 15, 0, 0);
      vecs[6]  = mk(1, 1, 1, 0, NONE, 0, 0, 15, 0, 0);
      vecs[7]  = mk(1, 1, 1, 1, DATA, 1, 0, 15, 1, 0);
      vecs[8]  = mk(1, 1, 1, 0, NONE, 0, 0, 14, 2, 0);
      vecs[9]  = mk(1, 1, 1, 1, RESP, 0, 1, 14, 3, 0);
      vecs[10] = mk(1, 1, 0, 0, NONE, 0, 0, 14, 4, 0);
      vecs[11] = mk(1, 1, 0, 1, CRD,  0, 0, 14, 4, 4);
      vecs[12] = mk(1, 1, 0, 0, NONE, 0, 0, 14, 0, 4);
      vecs[13] = mk(1, 1, 0, 1, DATA, 1, 0, 14, 0, 4);

      // Reset values and data streaming until credits run out.
      do_reset();
      chk("rst_irdy", int'(tx_if.lp_irdy_o), 0);
      chk("rst_sel", int'(tx_if.sel_o), int'(NONE));
      chk("rst_tx_crd", int'(tx_crd_o), 16);
      chk("rst_rx_pend", int'(rx_pend_o), 0);
      chk("rst_fcnt", int'(tx_if.crd_flit_cnt_o), 0);
      chk("rst_err", int'(crd_err_o), 0);
      chk("rst_pop", int'(tx_if.data_pop_o), 0);
      tx_if.data_req_i = 1'b1;
      tx_if.pl_trdy_i = 1'b1;
      tick();
      chk("first_irdy", int'(tx_if.lp_irdy_o), 1);
      chk("first_sel", int'(tx_if.sel_o), int'(DATA));
      chk("first_pop", int'(tx_if.data_pop_o), 1);
      pops = 1;
      last = 0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         tick();
         if (tx_if.data_pop_o) begin
            chk("pop_gap", cyc - last, 2);
            last = cyc;
            pops++;
         end
      end
      chk("pops_16", pops, 16);
      chk("tx_crd_empty", int'(tx_crd_o), 0);
      chk("stall_irdy", int'(tx_if.lp_irdy_o), 0);

      crd_ret_i = 1'b1;
      crd_ret_cnt_i = 6'd3;
      tick();
      crd_ret_i = 1'b0;
      crd_ret_cnt_i = '0;
      chk("ret3_tx_crd", int'(tx_crd_o), 3);
      pops = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         tick();
         if (tx_if.data_pop_o) pops++;
      end
      chk("pops_after_ret3", pops, 3);
      chk("tx_crd_empty2", int'(tx_crd_o), 0);
      tx_if.data_req_i = 1'b0;
      crd_ret_i = 1'b1;
      crd_ret_cnt_i = 6'd20;
      tick();
      crd_ret_i = 1'b0;
      crd_ret_cnt_i = '0;
      chk("ovf_tx_crd", int'(tx_crd_o), 16);
      chk("ovf_err", int'(crd_err_o), 1);

      // Table-driven arbitration vectors.
      do_reset();
      for (int i = 0; i < 14; i++) begin
         tx_if.data_req_i = vecs[i].dreq;
         tx_if.resp_req_i = vecs[i].rreq;
         tx_if.pl_trdy_i  = vecs[i].trdy;
         rx_pop_i         = vecs[i].pop;
         #1;
         chk($sformatf("v%0d_irdy", i), int'(tx_if.lp_irdy_o), int'(vecs[i].irdy));
         chk($sformatf("v%0d_sel", i), int'(tx_if.sel_o), int'(vecs[i].sel));
         chk($sformatf("v%0d_pop", i), int'(tx_if.data_pop_o), int'(vecs[i].dpop));
         chk($sformatf("v%0d_ack", i), int'(tx_if.resp_ack_o), int'(vecs[i].rack));
         chk($sformatf("v%0d_tx", i), int'(tx_crd_o), vecs[i].tx);
         chk($sformatf("v%0d_pend", i), int'(rx_pend_o), vecs[i].pend);
         chk($sformatf("v%0d_fcnt", i), int'(tx_if.crd_flit_cnt_o), vecs[i].fcnt);
         tick();
      end

      // Single pending credit returned only after the idle timeout.
      do_reset();
      rx_pop_i = 1'b1;
      tick();
      rx_pop_i = 1'b0;
      saw = 0;
      for (int i = 0; i < 59; i++) begin
         if (tx_if.lp_irdy_o) saw = 1;
         tick();
      end
      chk("tmo_early_grant", saw, 0);
      got = 0;
      for (int i = 0; i < 12; i++) begin
         if (tx_if.lp_irdy_o) begin
            got = 1;
            break;
         end
         tick();
      end
      chk("tmo_grant", got, 1);
      chk("tmo_sel", int'(tx_if.sel_o), int'(CRD));
      chk("tmo_fcnt", int'(tx_if.crd_flit_cnt_o), 1);
      tx_if.pl_trdy_i = 1'b1;
      tick();
      tx_if.pl_trdy_i = 1'b0;
      chk("tmo_pend_clr", int'(rx_pend_o), 0);
      chk("tmo_irdy_done", int'(tx_if.lp_irdy_o), 0);

      // Credit flit stalled by RDI while more pops arrive.
      do_reset();
      rx_pop_i = 1'b1;
      repeat (4) tick();
      rx_pop_i = 1'b0;
      chk("stall_pend4", int'(rx_pend_o), 4);
      chk("stall_idle", int'(tx_if.lp_irdy_o), 0);
      tick();
      chk("stall_irdy", int'(tx_if.lp_irdy_o), 1);
      for (int i = 0; i < 5; i++) begin
         rx_pop_i = (i < 2);
         tick();
         chk("stall_sel", int'(tx_if.sel_o), int'(CRD));
         chk("stall_fcnt", int'(tx_if.crd_flit_cnt_o), 4);
         chk("stall_hold", int'(tx_if.lp_irdy_o), 1);
      end
      rx_pop_i = 1'b0;
      chk("stall_pend6", int'(rx_pend_o), 6);
      tx_if.pl_trdy_i = 1'b1;
      tick();
      tx_if.pl_trdy_i = 1'b0;
      chk("stall_pend_after", int'(rx_pend_o), 2);
      chk("stall_done", int'(tx_if.lp_irdy_o), 0);
      chk("stall_err", int'(crd_err_o), 0);

      // Enable dropped mid-flit, then reset mid-flit.
      do_reset();
      tx_if.data_req_i = 1'b1;
      tick();
      chk("en_irdy", int'(tx_if.lp_irdy_o), 1);
      enable = 1'b0;
      repeat (3) tick();
      chk("en_hold", int'(tx_if.lp_irdy_o), 1);
      tx_if.pl_trdy_i = 1'b1;
      #1;
      chk("en_pop", int'(tx_if.data_pop_o), 1);
      tick();
      tx_if.pl_trdy_i = 1'b0;
      chk("en_done", int'(tx_if.lp_irdy_o), 0);
      chk("en_tx_crd", int'(tx_crd_o), 15);
      saw = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (tx_if.lp_irdy_o) saw = 1;
      end
      chk("en_no_grant", saw, 0);
      enable = 1'b1;
      tick();
      chk("en_regrant", int'(tx_if.lp_irdy_o), 1);
      tx_if.pl_trdy_i = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("rstmid_pop", int'(tx_if.data_pop_o), 0);
      chk("rstmid_irdy", int'(tx_if.lp_irdy_o), 0);
      chk("rstmid_sel", int'(tx_if.sel_o), int'(NONE));
      chk("rstmid_tx", int'(tx_crd_o), 16);
      chk("rstmid_pend", int'(rx_pend_o), 0);
      chk("rstmid_err", int'(crd_err_o), 0);
      tick();
      rst_n = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/rdi_tx_scheduler.md
# rdi_tx_scheduler

Sequences the protocol adapter's single RDI transmit slot among three flit sources: write data from the write FIFO, responses, and local credit returns. It owns the remote-credit counter that gates data flits and the local pending-credit accumulator that triggers credit-return flits. It drives the select and pop/ack strobes into the write datapath and the `lp_irdy`/`pl_trdy` handshake toward RDI, and replaces the ad-hoc `tx_cmd`/`rx_resp_cmd`/`rx_crd` sequencing in `adapter_core`.

## Interface
Parameters:
- `CRD_W`, 6: width of every credit counter.
- `CRD_INIT`, 16: remote RX buffer depth. This is the reset value and the ceiling of the TX credit counter.
- `CRD_THRESH`, 4: pending local credits that make a credit flit urgent.
- `CRD_TMO`, 64: idle cycles after which any nonzero pending credits are returned. Minimum 2.

Ports:
- `clk_i` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `enable` input 1: when low, no new grant; an in-flight flit completes.
- `data_req_i` input 1: write FIFO non-empty.
- `data_pop_o` output 1: write FIFO pop, one pulse per data flit.
- `resp_req_i` input 1: response pending.
- `resp_ack_o` output 1: response consumed, one pulse.
- `rx_pop_i` input 1: local read FIFO popped; one local credit freed.
- `crd_ret_i` input 1: remote credit-return flit received.
- `crd_ret_cnt_i` input CRD_W: number of credits carried by that flit.
- `sel_o` output 2: flit type currently presented to the datapath.
- `crd_flit_cnt_o` output CRD_W: credit count to encode in the outgoing credit flit.
- `lp_irdy_o` output 1: flit offered to RDI.
- `pl_trdy_i` input 1: RDI accepts the flit.
- `tx_crd_o` output CRD_W: current remote credits.
- `rx_pend_o` output CRD_W: current pending local credits.
- `crd_err_o` output 1: sticky credit overflow or underflow error.

## Operation
- FSM has two states, IDLE and SEND. Reset state is IDLE.
- IDLE → SEND when `enable` is high and any source is eligible. The winner is registered into `sel_o`. A credit winner also latches `crd_flit_cnt_o` = `rx_pend` in the same cycle.
- SEND → IDLE in the cycle where `pl_trdy_i` is high. `sel_o` and `crd_flit_cnt_o` stay stable throughout SEND.
- Eligibility rules:
  - DATA: `data_req_i` high and `tx_crd` > 0.
  - RESP: `resp_req_i` high.
  - CRD_URG: `rx_pend` ≥ `CRD_THRESH`.
  - CRD_TMO: `rx_pend` > 0 and the idle timer has reached `CRD_TMO`.
- Priority order: CRD_URG, then RESP and DATA, then CRD_TMO. RESP and DATA alternate round-robin. The RR pointer flips to the other source after either one is granted; it resets to favour RESP.
- Strobes, valid only in SEND with `pl_trdy_i` high:
  - `data_pop_o` = SEND & `pl_trdy_i` & (`sel_o` == DATA).
  - `resp_ack_o` the same, gated by `sel_o` == RESP.
- `tx_crd` update: next = `tx_crd` − `data_pop_o` + (`crd_ret_i` ? `crd_ret_cnt_i` : 0).
  - Simultaneous decrement and return is netted in one cycle.
  - If the result would exceed `CRD_INIT`, `tx_crd` saturates at `CRD_INIT` and `crd_err_o` sets.
  - Underflow cannot occur because of eligibility gating. If it does, `tx_crd` holds and `crd_err_o` sets.
- `rx_pend` update: next = `rx_pend` + `rx_pop_i` − (credit flit completion ? `crd_flit_cnt_o` : 0).
  - Pops that arrive while a credit flit is in SEND are kept for the next credit flit.
  - `rx_pend` saturates at all-ones and sets `crd_err_o`.
- Idle timer:
  - Clears whenever `rx_pend` == 0 or a credit flit completes.
  - Otherwise increments each cycle and saturates at `CRD_TMO`.
- `enable` low: IDLE takes no grant. SEND holds until `pl_trdy_i`. Counters keep tracking.

## Timing
- Reset values:
  - `sel_o` = NONE; `lp_irdy_o`, `data_pop_o`, `resp_ack_o`, `crd_err_o` = 0.
  - `crd_flit_cnt_o`, `rx_pend_o` = 0; `tx_crd_o` = `CRD_INIT`.
  - FSM = IDLE; RR pointer favours RESP; idle timer = 0.
- Reset asserted mid-SEND aborts the flit immediately. No strobe is emitted.
- `lp_irdy_o` and `sel_o` are registered: `lp_irdy_o` = (state == SEND). Request eligible in IDLE at cycle t gives `lp_irdy_o` high at t+1.
- Pop and ack strobes are combinational from `pl_trdy_i`, in the accept cycle.
- One mandatory IDLE bubble follows every transfer, so `data_req_i` reflects the FIFO after the pop. Peak throughput is one flit per 2 cycles.
- `tx_crd_o` and `rx_pend_o` are registered and reflect a cycle's events at the next edge.

## Structure
- Shared package `pa_pkg` holds:
  - `flit_sel_e` enum (2-bit): NONE=0, DATA=1, RESP=2, CRD=3.
  - `sched_state_e` enum: IDLE, SEND.
  - `CRD_W` default.
- Sub-module `tx_credit_counter`: saturating up/down counter with parameterised init and max, a netted increment and decrement, and a sticky error output. Instantiated twice, once for `tx_crd` and once for `rx_pend`.

## Test plan
- Reset, then `data_req_i`=1 with `pl_trdy_i`=1:
  - `lp_irdy_o` high 1 cycle after release with `sel_o`=DATA.
  - `data_pop_o` pulses every 2 cycles.
  - `tx_crd_o` goes 16→0 after 16 pops, then no further grants.
- `tx_crd`=0, then `crd_ret_i` with count 3: three more data flits, then stall. Returning 20 while `tx_crd`=0 → `tx_crd_o`=16 and `crd_err_o`=1.
- `data_req_i` and `resp_req_i` both held: grants alternate RESP, DATA, RESP, DATA. Four `rx_pop_i` pulses → the next grant is CRD with `crd_flit_cnt_o`=4, and `rx_pend_o` returns to 0.
- One `rx_pop_i` then no traffic: credit flit granted with count 1 once the timer reaches 64.
- Credit flit with `pl_trdy_i` held low 5 cycles while 2 `rx_pop_i` arrive: `sel_o` is stable, count 4 is sent, and `rx_pend_o`=2 after acceptance.
- `enable` dropped mid-SEND: flit completes on `pl_trdy_i`, then no grants. Reset asserted mid-SEND → all outputs return to reset values with no strobe.
